io_bus_bridge: RTL and testbench

IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

---
 rtl/io_bus_bridge_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/io_bus_bridge.sv | 114 +++++++++++
 tb/tb_io_bus_bridge.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_bridge_pkg.sv
// Shared constants and types for the processor I/O register bridge.
package io_bus_bridge_pkg;

  // Base of the 32-byte I/O window (0x0020-0x003F). Only [15:5] take part in decode.
  localparam logic [15:0] IO_BASE = 16'h0020;

  // Register indices, taken from AddressOut[1:0]; the window aliases every 4 words.
  localparam logic [1:0] IDX_LED    = 2'd0;
  localparam logic [1:0] IDX_HEX_LO = 2'd1;
  localparam logic [1:0] IDX_HEX_HI = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  // Bit of STATUS holding the sticky key event; a write with this bit set clears it.
  localparam int STATUS_EVT_BIT = 0;

  // The three processor-writable registers.
  typedef struct packed {
    logic [15:0] led;
    logic [15:0] hex_lo;
    logic [15:0] hex_hi;
  } io_regs_t;

  // True when an address falls inside the I/O window.
  function automatic logic is_io(input logic [15:0] addr);
    return addr[15:5] == IO_BASE[15:5];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  // Two back-to-back flops; meta_q may go metastable, q is the settled copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// Memory-mapped I/O bridge: LED/HEX registers, key event status, and the
// read-data mux that merges I/O reads with the external synchronous memory.
module io_bus_bridge
  import io_bus_bridge_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] AddressOut,
  input  logic [15:0] DOUT,
  input  logic        Write,
  input  logic [15:0] MemQ,
  input  logic [14:0] SW,
  input  logic        KeyN,
  output logic [15:0] DIN,
  output logic        MemWren,
  output logic [15:0] LED,
  output logic [31:0] HexVal
);

  logic        io_hit;
  logic [1:0]  idx;
  logic        wr_io;
  logic [14:0] sw_sync;
  logic        key_sync;
  logic        key_q;
  logic        key_fall;
  logic        evt_q;
  logic        evt_clr;
  logic [15:0] status_word;
  logic [15:0] rd_val;
  logic        sel_q;
  logic [15:0] rdata_q;
  io_regs_t    regs_q;

  assign io_hit  = is_io(AddressOut);
  assign idx     = AddressOut[1:0];
  assign wr_io   = Write & io_hit;
  // I/O writes are steered away from memory entirely.
  assign MemWren = Write & ~io_hit;

  sync_2ff #(.W(15), .RST_VAL(15'h0)) u_sw_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (SW),
    .q     (sw_sync)
  );

  // Key idles high, so its synchroniser resets to 1 to avoid a fake press on release.
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_key_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (KeyN),
    .q     (key_sync)
  );

  // Previous synchronised key level, for 1->0 edge detection.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) key_q <= 1'b1;
    else         key_q <= key_sync;
  end

  assign key_fall = key_q & ~key_sync;
  assign evt_clr  = wr_io && (idx == IDX_STATUS) && DOUT[STATUS_EVT_BIT];

  // Sticky event: a press edge wins over a coincident clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)       evt_q <= 1'b0;
    else if (key_fall) evt_q <= 1'b1;
    else if (evt_clr)  evt_q <= 1'b0;
  end

  // Processor-writable registers; STATUS writes only affect evt.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      regs_q <= '0;
    end else if (wr_io) begin
      case (idx)
        IDX_LED:    regs_q.led    <= DOUT;
        IDX_HEX_LO: regs_q.hex_lo <= DOUT;
        IDX_HEX_HI: regs_q.hex_hi <= DOUT;
        default:    ;
      endcase
    end
  end

  assign status_word = {sw_sync, evt_q};

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_LED:    rd_val = regs_q.led;
      IDX_HEX_LO: rd_val = regs_q.hex_lo;
      IDX_HEX_HI: rd_val = regs_q.hex_hi;
      default:    rd_val = status_word;
    endcase
  end

  // Register the read path every cycle so I/O reads share the memory's one-cycle latency.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sel_q   <= io_hit;
      rdata_q <= rd_val;
    end
  end

  assign DIN    = sel_q ? rdata_q : MemQ;
  assign LED    = regs_q.led;
  assign HexVal = {regs_q.hex_hi, regs_q.hex_lo};

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: a per-cycle vector table plus hand sequences
// for key events, set/clear collision and asynchronous reset.
module tb_io_bus_bridge;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] AddressOut;
  logic [15:0] DOUT;
  logic        Write;
  logic [15:0] MemQ;
  logic [14:0] SW;
  logic        KeyN;
  logic [15:0] DIN;
  logic        MemWren;
  logic [15:0] LED;
  logic [31:0] HexVal;

  int n_cmp = 0;
  int n_bad = 0;

  io_bus_bridge dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .AddressOut (AddressOut),
    .DOUT       (DOUT),
    .Write      (Write),
    .MemQ       (MemQ),
    .SW         (SW),
    .KeyN       (KeyN),
    .DIN        (DIN),
    .MemWren    (MemWren),
    .LED        (LED),
    .HexVal     (HexVal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] memq;
    logic [15:0] exp_din;
    logic        exp_mwe;
    logic [15:0] exp_led;
    logic [31:0] exp_hex;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, away from the edge.
  task automatic cyc();
    @(posedge Clock);
    #2;
  endtask

  task automatic drive(input logic wr, input logic [15:0] addr, input logic [15:0] dout,
                       input logic [15:0] memq);
    Write = wr; AddressOut = addr; DOUT = dout; MemQ = memq;
  endtask

  initial begin
    // Each row: inputs held for one cycle; outputs checked before that cycle's edge,
    // so register effects of a row show up in the following row.
    //             wr    addr      dout      memq      din       mwe   led       hex
    tbl[0]  = '{1'b1, 16'h0020, 16'hA5A5, 16'h1111, 16'h1111, 1'b0, 16'h0000, 32'h0000_0000};
    tbl[1]  = '{1'b0, 16'h0020, 16'h0000, 16'h2222, 16'h0000, 1'b0, 16'hA5A5, 32'h0000_0000};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 16'h3333, 16'hA5A5, 1'b0, 16'hA5A5, 32'h0000_0000};
    tbl[3]  = '{1'b1, 16'h0021, 16'h1234, 16'h4444, 16'h4444, 1'b0, 16'hA5A5, 32'h0000_0000};
    tbl[4]  = '{1'b1, 16'h0022, 16'hBEEF, 16'h5555, 16'h0000, 1'b0, 16'hA5A5, 32'h0000_1234};
    tbl[5]  = '{1'b0, 16'h0022, 16'h0000, 16'h6666, 16'h0000, 1'b0, 16'hA5A5, 32'hBEEF_1234};
    tbl[6]  = '{1'b0, 16'h0005, 16'h0000, 16'h7777, 16'hBEEF, 1'b0, 16'hA5A5, 32'hBEEF_1234};
    tbl[7]  = '{1'b1, 16'h0005, 16'h0077, 16'h8888, 16'h8888, 1'b1, 16'hA5A5, 32'hBEEF_1234};
    tbl[8]  = '{1'b0, 16'h0005, 16'h0000, 16'h9999, 16'h9999, 1'b0, 16'hA5A5, 32'hBEEF_1234};
    tbl[9]  = '{1'b1, 16'h0024, 16'h00FF, 16'hAAAA, 16'hAAAA, 1'b0, 16'hA5A5, 32'hBEEF_1234};
    tbl[10] = '{1'b0, 16'h0041, 16'h0000, 16'hBBBB, 16'hA5A5, 1'b0, 16'h00FF, 32'hBEEF_1234};
    tbl[11] = '{1'b1, 16'h0041, 16'hDEAD, 16'hCCCC, 16'hCCCC, 1'b1, 16'h00FF, 32'hBEEF_1234};
    tbl[12] = '{1'b0, 16'h001F, 16'h0000, 16'hDDDD, 16'hDDDD, 1'b0, 16'h00FF, 32'hBEEF_1234};
    tbl[13] = '{1'b1, 16'h001F, 16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 32'hBEEF_1234};
    tbl[14] = '{1'b0, 16'h0023, 16'h0000, 16'hEEEE, 16'hEEEE, 1'b0, 16'h00FF, 32'hBEEF_1234};
    tbl[15] = '{1'b0, 16'h0000, 16'h0000, 16'h1357, 16'h0000, 1'b0, 16'h00FF, 32'hBEEF_1234};

    // ---- reset state ----
    Resetn = 1'b0; SW = 15'h0; KeyN = 1'b1;
    drive(1'b1, 16'h0020, 16'h5A5A, 16'hCAFE);
    #1;
    check("rst_led", {16'h0, LED}, 32'h0);
    check("rst_hex", HexVal, 32'h0);
    check("rst_din_memq", {16'h0, DIN}, 32'h0000_CAFE);
    check("rst_mwe_io", {31'h0, MemWren}, 32'h0);
    cyc();
    drive(1'b1, 16'h0005, 16'h5A5A, 16'hCAFE);
    #1;
    check("rst_mwe_mem", {31'h0, MemWren}, 32'h1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0BAD);
    Resetn = 1'b1;
    cyc();
    #1;
    check("post_rst_din", {16'h0, DIN}, 32'h0000_0BAD);
    check("post_rst_led", {16'h0, LED}, 32'h0);
    cyc();

    // ---- vector table ----
    for (int i = 0; i < 16; i++) begin
      cyc();
      drive(tbl[i].wr, tbl[i].addr, tbl[i].dout, tbl[i].memq);
      #1;
      check($sformatf("v%0d_mwe", i), {31'h0, MemWren}, {31'h0, tbl[i].exp_mwe});
      check($sformatf("v%0d_din", i), {16'h0, DIN}, {16'h0, tbl[i].exp_din});
      check($sformatf("v%0d_led", i), {16'h0, LED}, {16'h0, tbl[i].exp_led});
      check($sformatf("v%0d_hex", i), HexVal, tbl[i].exp_hex);
    end

    // ---- key press: evt lands on the 3rd edge after KeyN falls ----
    drive(1'b0, 16'h0023, 16'h0000, 16'hF00D);
    SW = 15'h0003;
    repeat (4) cyc();
    #1;
    check("status_idle", {16'h0, DIN}, 32'h0000_0006);
    KeyN = 1'b0;
    repeat (3) cyc();
    #1;
    check("evt_not_before_3", {16'h0, DIN}, 32'h0000_0006);
    cyc();
    #1;
    check("evt_set_3cyc", {16'h0, DIN}, 32'h0000_0007);
    cyc();
    #1;
    check("evt_sticky_read", {16'h0, DIN}, 32'h0000_0007);
    // Write with bit0 clear must not clear evt.
    drive(1'b1, 16'h0023, 16'hFFFE, 16'hF00D);
    cyc();
    drive(1'b0, 16'h0023, 16'h0000, 16'hF00D);
    cyc();
    #1;
    check("evt_no_clr_bit0", {16'h0, DIN}, 32'h0000_0007);
    check("status_wr_led_keep", {16'h0, LED}, 32'h0000_00FF);
    // Clear while key is still held; no second event may follow.
    drive(1'b1, 16'h0023, 16'h0001, 16'hF00D);
    cyc();
    drive(1'b0, 16'h0023, 16'h0000, 16'hF00D);
    repeat (5) cyc();
    #1;
    check("evt_hold_no_second", {16'h0, DIN}, 32'h0000_0006);
    KeyN = 1'b1;
    repeat (5) cyc();
    #1;
    check("evt_release_none", {16'h0, DIN}, 32'h0000_0006);

    // ---- set wins over coincident clear ----
    KeyN = 1'b0;
    cyc();
    cyc();
    drive(1'b1, 16'h0023, 16'h0001, 16'hF00D);
    cyc();
    drive(1'b0, 16'h0023, 16'h0000, 16'hF00D);
    cyc();
    #1;
    check("evt_set_priority", {16'h0, DIN}, 32'h0000_0007);
    drive(1'b1, 16'h0023, 16'h0001, 16'hF00D);
    cyc();
    drive(1'b0, 16'h0023, 16'h0000, 16'hF00D);
    cyc();
    #1;
    check("evt_clear", {16'h0, DIN}, 32'h0000_0006);
    KeyN = 1'b1;
    repeat (4) cyc();

    // ---- asynchronous reset mid-sequence ----
    drive(1'b1, 16'h0020, 16'hFFFF, 16'h2468);
    cyc();
    drive(1'b0, 16'h0020, 16'h0000, 16'h2468);
    #1;
    check("led_ffff", {16'h0, LED}, 32'h0000_FFFF);
    cyc();
    #1;
    check("din_led_ffff", {16'h0, DIN}, 32'h0000_FFFF);
    drive(1'b1, 16'h0021, 16'h9999, 16'h2468);
    Resetn = 1'b0;
    #1;
    check("async_rst_led", {16'h0, LED}, 32'h0);
    check("async_rst_din", {16'h0, DIN}, 32'h0000_2468);
    cyc();
    #1;
    check("rst_mid_write_hex", HexVal, 32'h0);
    drive(1'b0, 16'h0023, 16'h0000, 16'h2468);
    Resetn = 1'b1;
    #1;
    check("rel_din_memq", {16'h0, DIN}, 32'h0000_2468);
    repeat (5) cyc();
    #1;
    check("rel_no_evt", {16'h0, DIN}, 32'h0000_0006);
    check("rel_hex_zero", HexVal, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
